// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor: windowed spike-rate counter with inter-spike interval and burst detection
module spike_rate_monitor #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8,
    parameter int ISI_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    input  logic [ISI_W-1:0] burst_thresh,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             burst
);
    typedef enum logic {IDLE, COUNT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};
    state_t state, state_nx;
    logic spike_d, have_prev, sat, spike_evt, counting, win_end, sat_next;
    logic [WIN_W-1:0] win_len_q, win_cnt;
    logic [CNT_W-1:0] spk_cnt, spk_next;
    logic [ISI_W-1:0] isi_cnt;
    assign spike_evt = spike_in & ~spike_d;
    assign counting = (state == COUNT) && enable;
    assign win_end = counting && (win_cnt == win_len_q - WIN_W'(1));
    assign spk_next = spk_cnt + CNT_W'(spike_evt && spk_cnt != CNT_MAX);
    assign sat_next = sat | (spike_evt && spk_cnt == CNT_MAX);
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (enable && window_len != '0) ? COUNT : IDLE;
        else
            state_nx = (!enable || (win_end && window_len == '0)) ? IDLE : COUNT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            spike_d    <= 1'b0;
            have_prev  <= 1'b0;
            sat        <= 1'b0;
            win_len_q  <= '0;
            win_cnt    <= '0;
            spk_cnt    <= '0;
            isi_cnt    <= '0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            rate_sat   <= 1'b0;
            isi_out    <= '0;
            isi_valid  <= 1'b0;
            burst      <= 1'b0;
        end else begin
            state      <= state_nx;
            spike_d    <= spike_in;
            rate_valid <= 1'b0;
            isi_valid  <= 1'b0;
            if (!counting) begin
                // While idle, win_len_q tracks window_len so the entry edge latches it
                win_len_q <= window_len;
                win_cnt   <= '0;
                spk_cnt   <= '0;
                sat       <= 1'b0;
                isi_cnt   <= '0;
                have_prev <= 1'b0;
            end else begin
                if (win_end) begin
                    rate_out   <= spk_next;
                    rate_sat   <= sat_next;
                    rate_valid <= 1'b1;
                    win_cnt    <= '0;
                    spk_cnt    <= '0;
                    sat        <= 1'b0;
                    win_len_q  <= window_len;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    spk_cnt <= spk_next;
                    sat     <= sat_next;
                end
                // isi_cnt holds cycles elapsed since the previous event, saturating
                if (spike_evt) begin
                    isi_cnt   <= ISI_W'(1);
                    have_prev <= 1'b1;
                    if (have_prev) begin
                        isi_out   <= isi_cnt;
                        isi_valid <= 1'b1;
                        burst     <= (isi_cnt <= burst_thresh);
                    end
                end else if (have_prev && isi_cnt != ISI_MAX) begin
                    isi_cnt <= isi_cnt + ISI_W'(1);
                end
                if (win_end && window_len == '0)
                    have_prev <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spike_rate_monitor.sv
// tb_spike_rate_monitor: random and directed stimulus against a cycle-indexed reference model
module tb_spike_rate_monitor;
    localparam int WIN_W = 8, CNT_W = 6, ISI_W = 8;
    localparam int CMAX = (1 << CNT_W) - 1, IMAX = (1 << ISI_W) - 1;
    logic clk = 0, rst = 1, enable = 0, spike_in = 0;
    logic [WIN_W-1:0] window_len = '0;
    logic [ISI_W-1:0] burst_thresh = '0;
    logic [CNT_W-1:0] rate_out;
    logic [ISI_W-1:0] isi_out;
    logic rate_valid, rate_sat, isi_valid, burst;
    int n_chk = 0, n_err = 0;
    spike_rate_monitor #(.WIN_W(WIN_W), .CNT_W(CNT_W), .ISI_W(ISI_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .burst_thresh(burst_thresh),
        .rate_out(rate_out), .rate_valid(rate_valid), .rate_sat(rate_sat),
        .isi_out(isi_out), .isi_valid(isi_valid), .burst(burst)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask
    // Reference: absolute cycle numbers, unbounded event counts, clipped only when reported
    int t = 0, pos = 0, len = 0, cnt = 0, last = -1;
    bit started = 0, in_cnt = 0, prev = 0, ev;
    int e_rate = 0, e_sat = 0, e_rv = 0, e_isi = 0, e_iv = 0, e_burst = 0;
    always @(posedge clk) begin
        started = 1;
        e_rv = 0;
        e_iv = 0;
        if (rst) begin
            e_rate = 0; e_sat = 0; e_isi = 0; e_burst = 0;
            in_cnt = 0; last = -1; prev = 0;
        end else begin
            ev = spike_in && !prev;
            if (!in_cnt) begin
                if (enable && window_len != 0) begin
                    in_cnt = 1; pos = 0; len = int'(window_len); cnt = 0; last = -1;
                end
            end else if (!enable) begin
                in_cnt = 0; last = -1;
            end else begin
                if (ev) begin
                    cnt++;
                    if (last >= 0) begin
                        e_isi = (t - last > IMAX) ? IMAX : t - last;
                        e_iv = 1;
                        e_burst = int'(e_isi <= int'(burst_thresh));
                    end
                    last = t;
                end
                if (pos == len - 1) begin
                    e_rate = (cnt > CMAX) ? CMAX : cnt;
                    e_sat = int'(cnt > CMAX);
                    e_rv = 1;
                    pos = 0; cnt = 0; len = int'(window_len);
                    if (len == 0) begin in_cnt = 0; last = -1; end
                end else pos++;
            end
            prev = spike_in;
        end
        t++;
    end
    always @(negedge clk) if (started) begin
        chk("rate_out", int'(rate_out), e_rate);
        chk("rate_valid", int'(rate_valid), e_rv);
        chk("rate_sat", int'(rate_sat), e_sat);
        chk("isi_out", int'(isi_out), e_isi);
        chk("isi_valid", int'(isi_valid), e_iv);
        chk("burst", int'(burst), e_burst);
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        cyc(2);
        chk("reset_rate", int'(rate_out), 0);
        // Spikes at window cycles 2, 5, 9 of a 10-cycle window
        rst = 0; window_len = 10; enable = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk) spike_in = (k == 2 || k == 5 || k == 9);
        end
        @(negedge clk) spike_in = 0; enable = 0;
        chk("plan_rate3", int'(rate_out), 3);
        chk("plan_isi4", int'(isi_out), 4);
        chk("plan_sat0", int'(rate_sat), 0);
        // Level already high at enable rise, then a 5-cycle high pulse
        spike_in = 1;
        cyc(1);
        enable = 1;
        cyc(3);
        spike_in = 0;
        cyc(2);
        spike_in = 1;
        cyc(5);
        spike_in = 0;
        cyc(6);
        enable = 0;
        cyc(2);
        // Toggling every cycle overflows the 6-bit count, then a quiet window
        window_len = 255; enable = 1;
        for (int k = 0; k < 255; k++) begin
            @(negedge clk) spike_in = (k % 2 == 0);
        end
        @(negedge clk) spike_in = 0;
        chk("toggle_rate", int'(rate_out), CMAX);
        chk("toggle_sat", int'(rate_sat), 1);
        cyc(254);
        @(negedge clk) enable = 0;
        chk("quiet_rate", int'(rate_out), 0);
        chk("quiet_sat", int'(rate_sat), 0);
        // Burst threshold 4 with spikes at 0, 3, 20
        burst_thresh = 4; window_len = 50; enable = 1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk) spike_in = (k == 0 || k == 3 || k == 20);
        end
        @(negedge clk) spike_in = 0;
        chk("burst_off", int'(burst), 0);
        chk("burst_isi17", int'(isi_out), 17);
        // Spikes 300 cycles apart saturate the ISI
        for (int k = 0; k <= 300; k++) begin
            @(negedge clk) spike_in = (k == 0 || k == 300);
        end
        @(negedge clk) spike_in = 0;
        chk("isi_sat", int'(isi_out), IMAX);
        enable = 0;
        cyc(2);
        // Disable mid-window, re-enable, then reset mid-window
        window_len = 20; enable = 1;
        cyc(2);
        spike_in = 1;
        cyc(1);
        spike_in = 0;
        cyc(3);
        enable = 0;
        cyc(4);
        enable = 1;
        cyc(2);
        spike_in = 1;
        cyc(1);
        spike_in = 0;
        cyc(4);
        spike_in = 1;
        cyc(1);
        spike_in = 0;
        cyc(3);
        rst = 1;
        @(negedge clk) rst = 0;
        chk("rst_rate", int'(rate_out), 0);
        chk("rst_isi", int'(isi_out), 0);
        chk("rst_burst", int'(burst), 0);
        // Random traffic
        enable = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom % 700 == 0);
            if ($urandom % 80 == 0) enable = ~enable;
            if ($urandom % 25 == 0) window_len = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            if ($urandom % 30 == 0) burst_thresh = 8'($urandom_range(0, 15));
            if ($urandom % 3 != 0) spike_in = ($urandom % 4 == 0);
        end
        rst = 0; enable = 0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
